// File: rtl/cache_line_fetcher.sv
// Hit-path line fetcher: latches the selected way's line, streams wrap-ordered beats.
// Optional multi-hit/miss flag on rspErr: define CACHE_FETCH_MULTIHIT_CHECK_EN.
module cache_line_fetcher #(
  parameter int NUM_WAYS       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int OW = $clog2(WORDS_PER_LINE),
  localparam int LW = WORDS_PER_LINE * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic [NUM_WAYS-1:0]    targetWay,
  input  logic [OW-1:0]          wordOffset,
  input  logic                   reqBurst,
  input  logic [NUM_WAYS*LW-1:0] wayData,
  output logic                   rspValid,
  input  logic                   rspReady,
  output logic [DATA_WIDTH-1:0]  rspData,
  output logic                   rspLast,
  output logic                   rspErr
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic [OW-1:0]   off_q, off_d;
  logic [OW-1:0]   beat_q, beat_d;
  logic            burst_q, burst_d;
  logic [LW-1:0]   line_sel;
  logic [OW-1:0]   word_sel;
  logic            accept;
  logic            beat_hs;
  logic            last_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (reqValid) state_d = SEND;
      SEND: if (last_hs && !reqValid) state_d = IDLE;
    endcase
  end

  always_comb begin
    rspValid = 1'b0;
    rspLast  = 1'b0;
    reqReady = 1'b0;
    unique case (state_q)
      IDLE: reqReady = 1'b1;
      SEND: begin
        rspValid = 1'b1;
        rspLast  = !burst_q || (beat_q == OW'(WORDS_PER_LINE - 1));
        reqReady = rspReady && rspLast;
      end
    endcase
  end

  assign accept  = reqValid && reqReady;
  assign beat_hs = rspValid && rspReady;
  assign last_hs = beat_hs && rspLast;

  // Multiple hits merge by OR; an all-zero vector yields a zero line
  always_comb begin
    line_sel = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (targetWay[w]) line_sel = line_sel | wayData[w*LW +: LW];
  end

  always_comb begin
    line_d  = line_q;
    off_d   = off_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    if (accept) begin
      line_d  = line_sel;
      off_d   = wordOffset;
      burst_d = reqBurst;
      beat_d  = '0;
    end else if (beat_hs) begin
      beat_d  = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q  <= '0;
      off_q   <= '0;
      burst_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      line_q  <= line_d;
      off_q   <= off_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
    end
  end

  assign word_sel = off_q + beat_q;
  assign rspData  = line_q[int'(word_sel)*DATA_WIDTH +: DATA_WIDTH];

`ifdef CACHE_FETCH_MULTIHIT_CHECK_EN
  logic err_q, err_d;
  logic err_new;

  assign err_new = (targetWay == '0) ||
                   ((targetWay & (targetWay - NUM_WAYS'(1))) != '0);

  always_comb begin
    err_d = err_q;
    if (accept) err_d = err_new;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign rspErr = rspValid && err_q;
`else
  assign rspErr = 1'b0;
`endif

endmodule

// File: tb/tb_cache_line_fetcher.sv
// Scoreboard bench for cache_line_fetcher (8 ways, 4 words, 32 bits).
// Error expectations follow CACHE_FETCH_MULTIHIT_CHECK_EN.
module tb_cache_line_fetcher;
  localparam int NW = 8;
  localparam int DW = 32;
  localparam int WL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reqValid;
  logic              reqReady;
  logic [NW-1:0]     targetWay;
  logic [1:0]        wordOffset;
  logic              reqBurst;
  logic [NW*WL*DW-1:0] wayData;
  logic              rspValid;
  logic              rspReady;
  logic [DW-1:0]     rspData;
  logic              rspLast;
  logic              rspErr;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          e;
  } beat_t;

  beat_t q[$];
  int nvec = 0;
  int nerr = 0;

  cache_line_fetcher #(
    .NUM_WAYS(NW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .targetWay(targetWay), .wordOffset(wordOffset),
    .reqBurst(reqBurst), .wayData(wayData),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData), .rspLast(rspLast), .rspErr(rspErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NW*WL; i++)
      wayData[i*DW +: DW] = $urandom;
  endtask

  task automatic push_exp(input logic [NW-1:0] tw,
                          input int off, input logic burst);
    int n;
    beat_t b;
    n = burst ? WL : 1;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (off + k) % WL;
      b.d = '0;
      for (int w = 0; w < NW; w++)
        if (tw[w]) b.d = b.d | wayData[(w*WL+idx)*DW +: DW];
      b.l = (k == n-1);
`ifdef CACHE_FETCH_MULTIHIT_CHECK_EN
      b.e = ($countones(tw) != 1);
`else
      b.e = 1'b0;
`endif
      q.push_back(b);
    end
  endtask

  // Called and returns at posedge+1; on return beat 0 is presented
  task automatic send_req(input logic [NW-1:0] tw,
                          input int off, input logic burst);
    bit ok;
    ok = 0;
    reqValid   = 1'b1;
    targetWay  = tw;
    wordOffset = 2'(off);
    reqBurst   = burst;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (reqReady) begin
        push_exp(tw, off, burst);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    if (!ok) chk("req_timeout", 0, 1);
    else     chk("lat", rspValid, 1);
    rand_data();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);
    chk("idle_vld", rspValid, 0);
    chk("idle_rdy", reqReady, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && rspValid && rspReady) begin
      if (q.size() == 0) begin
        chk("unexp_beat", 1, 0);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("data", rspData, e.d);
        chk("last", rspLast, e.l);
        chk("err", rspErr, e.e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    reqValid = 1'b0;
    targetWay = '0;
    wordOffset = '0;
    reqBurst = 1'b0;
    rspReady = 1'b1;
    rand_data();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", rspValid, 0);
    chk("rst_data", rspData, 0);
    chk("rst_last", rspLast, 0);
    chk("rst_err", rspErr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", reqReady, 1);

    send_req(8'h04, 2, 1'b1);
    drain();

    send_req(8'h80, 3, 1'b0);
    drain();

    // Stall on beat 1 with wayData churning underneath
    send_req(8'h01, 1, 1'b1);
    @(posedge clk); #1;
    rspReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      @(negedge clk);
      chk("stall_vld", rspValid, 1);
      chk("stall_data", rspData, q[0].d);
      chk("stall_last", rspLast, q[0].l);
      @(posedge clk); #1;
    end
    rspReady = 1'b1;
    drain();

    // Next request accepted on the last beat, no bubble
    send_req(8'h02, 0, 1'b1);
    send_req(8'h40, 1, 1'b0);
    send_req(8'h10, 3, 1'b1);
    drain();

    send_req(8'h00, 1, 1'b1);
    drain();
    send_req(8'h03, 0, 1'b1);
    drain();

    for (int i = 0; i < 8; i++)
      send_req(NW'(1) << $urandom_range(NW-1),
               int'($urandom_range(WL-1)), 1'($urandom));
    drain();

    // Reset while beat 2 of a burst is presented
    send_req(8'h20, 1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    chk("mrst_vld", rspValid, 0);
    chk("mrst_rdy", reqReady, 1);
    chk("mrst_data", rspData, 0);
    chk("mrst_last", rspLast, 0);
    chk("mrst_err", rspErr, 0);

    send_req(8'h08, 2, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cache_line_fetcher.md
CACHE_LINE_FETCHER -- requirements
Module: cache_line_fetcher

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 8, number of ways (1..512).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per word.
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4, words per line (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port reqValid  input  1  hit-fetch request valid.
REQ-007 SHALL have port reqReady  output  1  request accepted when reqValid && reqReady.
REQ-008 SHALL have port targetWay  input  NUM_WAYS  one-hot hit vector, sampled at accept.
REQ-009 SHALL have port wordOffset  input  log2(WORDS_PER_LINE)  critical-word index, sampled at accept.
REQ-010 SHALL have port reqBurst  input  1  1 = full-line wrap burst, 0 = single word, sampled at accept.
REQ-011 SHALL have port wayData  input  NUM_WAYS*WORDS_PER_LINE*DATA_WIDTH  flattened line data; way w, word k at bit offset (w*WORDS_PER_LINE+k)*DATA_WIDTH.
REQ-012 SHALL have port rspValid  output  1  response beat valid.
REQ-013 SHALL have port rspReady  input  1  beat consumed when rspValid && rspReady.
REQ-014 SHALL have port rspData  output  DATA_WIDTH  response word.
REQ-015 SHALL have port rspLast  output  1  final beat of current response.
REQ-016 SHALL have port rspErr  output  1  targetWay not one-hot (see Configuration).

Function
REQ-017 SHALL implement states IDLE and SEND.
REQ-018 SHALL drive reqReady=1 in IDLE, and in SEND only during the cycle the last beat handshakes; else 0.
REQ-019 SHALL, at accept, capture into a local line buffer the OR over all ways w with targetWay[w]=1 of that way's full line, plus wordOffset, reqBurst and error status; wayData is ignored thereafter.
REQ-020 SHALL present the first beat with rspValid=1 in the cycle after accept (latency 1).
REQ-021 SHALL output word (wordOffset+k) mod WORDS_PER_LINE on beat k, k=0..N-1, N=WORDS_PER_LINE if reqBurst else 1.
REQ-022 SHALL hold rspData, rspLast and rspErr stable while rspValid && !rspReady.
REQ-023 SHALL assert rspLast only on beat N-1; rspErr constant over all beats of a response.
REQ-024 SHALL, on last-beat handshake without new accept, return to IDLE with rspValid=0 the next cycle.
REQ-025 SHALL, on last-beat handshake with simultaneous accept, stay in SEND and present the new request's beat 0 the next cycle (no bubble).
REQ-026 SHALL output rspData=0 for all beats when targetWay is all-zero.
REQ-027 SHALL keep the beat counter log2(WORDS_PER_LINE) bits, wrap-around modulo WORDS_PER_LINE.

Reset
REQ-028 SHALL, when rst_n=0 at a rising edge, enter IDLE and clear rspValid, rspLast, rspErr, rspData, beat counter and line buffer to 0, regardless of state.
REQ-029 SHALL discard any in-progress response on reset; reqReady=1 on the first cycle after rst_n returns to 1.

Configuration
REQ-030 SHALL support macro CACHE_FETCH_MULTIHIT_CHECK_EN.
REQ-031 SHALL, with the macro defined, set the captured error bit when popcount(targetWay) != 1 and drive it on rspErr; data per REQ-019 (OR of selected ways).
REQ-032 SHALL, with the macro undefined, tie rspErr to 0 and omit the popcount logic; data unchanged.

Verification
REQ-033 SHALL cover: NUM_WAYS=8, WORDS_PER_LINE=4, targetWay=8'h04, wordOffset=2, reqBurst=1, rspReady=1 -> beats words 2,3,0,1 of way 2 on 4 consecutive cycles starting accept+1, rspLast on 4th, rspErr=0.
REQ-034 SHALL cover: reqBurst=0, wordOffset=3, targetWay=8'h80 -> single beat of way 7 word 3 with rspLast=1, IDLE next cycle.
REQ-035 SHALL cover: rspReady held 0 for 3 cycles on beat 1 -> rspData/rspLast unchanged, wayData changes after accept have no effect.
REQ-036 SHALL cover: new request offered during last beat with rspReady=1 -> accepted same cycle, its beat 0 valid next cycle, no rspValid gap.
REQ-037 SHALL cover: targetWay=8'h00 then 8'h03 with macro defined -> rspData=0 / rspData=way0|way1, rspErr=1 on all beats; macro undefined -> rspErr=0.
REQ-038 SHALL cover: rst_n=0 during beat 2 of a burst -> next cycle rspValid=0, reqReady=1, all outputs 0.
